// File: rtl/sched_pkg.sv
// Shared types and the round-robin pick function for the time-slice scheduler.
// rr_pick is written for up to MAX_REQ requesters; callers pass their real count.
package sched_pkg;

    localparam int NREQ_DEF = 4;
    localparam int N_DEF    = 8;
    localparam int ID_W     = $clog2(NREQ_DEF);
    localparam int MAX_REQ  = 32;
    localparam int MAX_ID_W = $clog2(MAX_REQ);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    typedef struct packed {
        logic                valid;
        logic [MAX_ID_W-1:0] idx;
    } pick_t;

    // First set bit of req searching from ptr+1 upward, wrapping at nreq.
    function automatic pick_t rr_pick(input logic [MAX_REQ-1:0]  req,
                                      input int unsigned         nreq,
                                      input logic [MAX_ID_W-1:0] ptr);
        pick_t       r;
        logic [31:0] j;
        r = '0;
        for (int unsigned i = 1; i <= MAX_REQ; i++) begin
            j = (32'(ptr) + i) % nreq;
            if (i <= nreq && !r.valid && req[j[MAX_ID_W-1:0]]) begin
                r.valid = 1'b1;
                r.idx   = j[MAX_ID_W-1:0];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/timeslice_rr_scheduler_slot_timer.sv
// Mod-k slot timer: load latches k and restarts at 0, clear restarts at 0.
// k == 0 means unlimited: the count saturates at all-ones and never expires.
module slot_timer #(
    parameter int N = 8
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         clear_i,
    input  logic         load_i,
    input  logic [N-1:0] k_i,
    output logic [N-1:0] count_o,
    output logic         expire_o
);

    logic [N-1:0] count_q, count_d;
    logic [N-1:0] k_q, k_d;

    assign count_o  = count_q;
    assign expire_o = (k_q != '0) && (count_q == k_q - 1'b1);

    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        count_d = count_q;
        k_d     = k_q;
        if (load_i) begin
            k_d     = k_i;
            count_d = '0;
        end else if (clear_i) begin
            count_d = '0;
        end else if (k_q == '0) begin
            if (count_q != '1) count_d = count_q + 1'b1;
        end else if (expire_o) begin
            count_d = '0;
        end else begin
            count_d = count_q + 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            count_q <= '0;
            k_q     <= '0;
        end else begin
            count_q <= count_d;
            k_q     <= k_d;
        end
    end

endmodule

// File: rtl/timeslice_rr_scheduler.sv
// Time-slice round-robin scheduler: one-hot registered grant, slots end on
// holder release/drop (priority) or on quantum expiry, with no bubble between slots.
module timeslice_rr_scheduler
    import sched_pkg::*;
#(
    parameter  int NREQ = NREQ_DEF,
    parameter  int N    = N_DEF,
    localparam int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic [N-1:0]    i_quantum,
    input  logic [NREQ-1:0] i_req,
    input  logic [NREQ-1:0] i_release,
    output logic [NREQ-1:0] o_grant,
    output logic            o_grant_valid,
    output logic [IDW-1:0]  o_grant_id,
    output logic [N-1:0]    o_slot_count,
    output logic            o_slot_expired
);

    state_t          state_q, state_d;
    logic [NREQ-1:0] grant_q, grant_d;
    logic [IDW-1:0]  holder_q, holder_d;
    logic [IDW-1:0]  ptr_q, ptr_d;
    logic            expired_q, expired_d;

    logic            t_clear, t_load, t_expire;
    logic [N-1:0]    t_count;
    logic            rel_end, exp_end;
    logic [NREQ-1:0] arb_req;
    logic [IDW-1:0]  arb_ptr;
    pick_t           pick;

    slot_timer #(.N(N)) u_timer (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .clear_i  (t_clear),
        .load_i   (t_load),
        .k_i      (i_quantum),
        .count_o  (t_count),
        .expire_o (t_expire)
    );

    // A releasing holder is excluded from the re-arbitration; an expiring one is not.
    always_comb begin
        rel_end = (state_q == GRANT) && (!i_req[holder_q] || i_release[holder_q]);
        exp_end = (state_q == GRANT) && !rel_end && t_expire;
        arb_req = i_req;
        if (rel_end) arb_req[holder_q] = 1'b0;
        arb_ptr = (state_q == GRANT) ? holder_q : ptr_q;
        pick    = rr_pick(MAX_REQ'(arb_req), NREQ, MAX_ID_W'(arb_ptr));
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        holder_d  = holder_q;
        ptr_d     = ptr_q;
        expired_d = 1'b0;
        t_load    = 1'b0;
        t_clear   = 1'b0;
        case (state_q)
            IDLE: begin
                t_clear = 1'b1;
                if (pick.valid) begin
                    state_d  = GRANT;
                    holder_d = pick.idx[IDW-1:0];
                    grant_d  = {{(NREQ-1){1'b0}}, 1'b1} << pick.idx[IDW-1:0];
                    t_load   = 1'b1;
                end
            end
            GRANT: begin
                if (rel_end || exp_end) begin
                    ptr_d     = holder_q;
                    expired_d = exp_end;
                    if (pick.valid) begin
                        holder_d = pick.idx[IDW-1:0];
                        grant_d  = {{(NREQ-1){1'b0}}, 1'b1} << pick.idx[IDW-1:0];
                        t_load   = 1'b1;
                    end else begin
                        state_d  = IDLE;
                        holder_d = '0;
                        grant_d  = '0;
                        t_clear  = 1'b1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            holder_q  <= '0;
            ptr_q     <= IDW'(NREQ - 1);
            expired_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            holder_q  <= holder_d;
            ptr_q     <= ptr_d;
            expired_q <= expired_d;
        end
    end

    assign o_grant        = grant_q;
    assign o_grant_valid  = |grant_q;
    assign o_grant_id     = holder_q;
    assign o_slot_count   = t_count;
    assign o_slot_expired = expired_q;

endmodule

// File: tb/tb_timeslice_rr_scheduler.sv
// Directed bench for timeslice_rr_scheduler: hand-computed grant/count/pulse
// sequences for rotation, sole holder, release, saturation and quantum latching.
module tb_timeslice_rr_scheduler;

    logic       i_clk = 1'b0;
    logic       i_reset;
    logic [7:0] i_quantum;
    logic [3:0] i_req;
    logic [3:0] i_release;
    logic [3:0] o_grant;
    logic       o_grant_valid;
    logic [1:0] o_grant_id;
    logic [7:0] o_slot_count;
    logic       o_slot_expired;

    int vectors     = 0;
    int miscompares = 0;

    timeslice_rr_scheduler #(.NREQ(4), .N(8)) dut (
        .i_clk          (i_clk),
        .i_reset        (i_reset),
        .i_quantum      (i_quantum),
        .i_req          (i_req),
        .i_release      (i_release),
        .o_grant        (o_grant),
        .o_grant_valid  (o_grant_valid),
        .o_grant_id     (o_grant_id),
        .o_slot_count   (o_slot_count),
        .o_slot_expired (o_slot_expired)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] id_of(input logic [3:0] g);
        case (g)
            4'b0010: return 2'd1;
            4'b0100: return 2'd2;
            4'b1000: return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [3:0] g, input int cnt, input logic ex);
        check({tag, ".grant"},   32'(o_grant),        32'(g));
        check({tag, ".valid"},   32'(o_grant_valid),  32'(|g));
        check({tag, ".id"},      32'(o_grant_id),     32'(id_of(g)));
        check({tag, ".count"},   32'(o_slot_count),   cnt);
        check({tag, ".expired"}, 32'(o_slot_expired), 32'(ex));
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    initial begin
        logic saw_exp;
        i_reset   = 1'b1;
        i_quantum = 8'd0;
        i_req     = 4'b0000;
        i_release = 4'b0000;
        repeat (3) tick();
        chk("reset", 4'b0000, 0, 1'b0);
        i_reset = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            chk($sformatf("idle[%0d]", k), 4'b0000, 0, 1'b0);
        end

        // q=3, two requesters rotate every 3 cycles with a pulse at each switch
        i_quantum = 8'd3;
        i_req     = 4'b0011;
        for (int k = 0; k < 9; k++) begin
            tick();
            chk($sformatf("rr3[%0d]", k), ((k / 3) % 2 == 1) ? 4'b0010 : 4'b0001,
                k % 3, (k >= 3) && (k % 3 == 0));
        end
        i_req = 4'b0000;   // holder drops on its expiry cycle: release wins
        tick();
        chk("rr3.drop", 4'b0000, 0, 1'b0);

        // q=4, sole requester 2 is re-granted on every expiry
        i_quantum = 8'd4;
        i_req     = 4'b0100;
        for (int k = 0; k < 12; k++) begin
            tick();
            chk($sformatf("solo4[%0d]", k), 4'b0100, k % 4, (k >= 4) && (k % 4 == 0));
        end
        i_req = 4'b0000;
        tick();
        chk("solo4.drop", 4'b0000, 0, 1'b0);

        // asynchronous reset in the middle of a slot
        i_quantum = 8'd0;
        i_req     = 4'b0001;
        tick();
        chk("rst.slot0", 4'b0001, 0, 1'b0);
        tick();
        chk("rst.slot1", 4'b0001, 1, 1'b0);
        #2 i_reset = 1'b1;
        #1 chk("rst.async", 4'b0000, 0, 1'b0);
        tick();
        i_req   = 4'b0000;
        i_reset = 1'b0;
        tick();
        chk("rst.after", 4'b0000, 0, 1'b0);

        // q=5, holder 0 releases at count 1, requester 3 takes over with no pulse
        i_quantum = 8'd5;
        i_req     = 4'b1001;
        tick();
        chk("rel.c0", 4'b0001, 0, 1'b0);
        tick();
        chk("rel.c1", 4'b0001, 1, 1'b0);
        i_release = 4'b0001;
        tick();
        chk("rel.switch", 4'b1000, 0, 1'b0);
        i_release = 4'b0000;
        tick();
        chk("rel.next", 4'b1000, 1, 1'b0);
        i_req = 4'b0000;
        tick();
        chk("rel.drop", 4'b0000, 0, 1'b0);

        // q=0, unlimited slot: count saturates at 255, never expires
        i_quantum = 8'd0;
        i_req     = 4'b0010;
        tick();
        chk("sat.c0", 4'b0010, 0, 1'b0);
        saw_exp = 1'b0;
        for (int k = 1; k < 300; k++) begin
            tick();
            if (o_slot_expired) saw_exp = 1'b1;
            if (k == 200) check("sat.count200", 32'(o_slot_count), 200);
            if (k == 255) check("sat.count255", 32'(o_slot_count), 255);
        end
        chk("sat.end", 4'b0010, 255, 1'b0);
        check("sat.no_expiry", 32'(saw_exp), 0);
        i_req = 4'b0000;
        tick();
        chk("sat.drop", 4'b0000, 0, 1'b0);

        // q=2, release and expiry in the same cycle; then a mid-slot quantum change
        i_quantum = 8'd2;
        i_req     = 4'b0011;
        tick();
        chk("both.c0", 4'b0001, 0, 1'b0);
        tick();
        chk("both.c1", 4'b0001, 1, 1'b0);
        i_release = 4'b0001;
        tick();
        chk("both.switch", 4'b0010, 0, 1'b0);
        i_release = 4'b0000;
        i_quantum = 8'd7;
        tick();
        chk("qchg.c1", 4'b0010, 1, 1'b0);
        tick();
        chk("qchg.expire", 4'b0001, 0, 1'b1);
        tick();
        chk("qchg.q7a", 4'b0001, 1, 1'b0);
        tick();
        chk("qchg.q7b", 4'b0001, 2, 1'b0);
        i_req = 4'b0000;
        tick();
        chk("qchg.drop", 4'b0000, 0, 1'b0);

        // q=1: rotation every cycle, then sole-holder re-grant every cycle
        i_quantum = 8'd1;
        i_req     = 4'b0101;
        tick();
        chk("q1.a", 4'b0100, 0, 1'b0);
        tick();
        chk("q1.b", 4'b0001, 0, 1'b1);
        tick();
        chk("q1.c", 4'b0100, 0, 1'b1);
        tick();
        chk("q1.d", 4'b0001, 0, 1'b1);
        i_req = 4'b0001;
        tick();
        chk("q1.solo", 4'b0001, 0, 1'b1);
        i_req = 4'b0000;
        tick();
        chk("q1.drop", 4'b0000, 0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
